// File: rtl/imem_fetch_responder_if.sv
// imem_fetch_responder_if: fetch request/response handshake between PC (master) and instruction memory (slave).
interface imem_fetch_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_fault;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: instruction store answering one fetch at a time after LATENCY wait states,
// with a side preload port and alignment/range fault reporting.
module imem_fetch_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imem_fetch_responder_if.slave fetch,
    input  logic                  load_en,
    input  logic [31:0]           load_addr,
    input  logic [31:0]           load_data,
    output logic                  busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   addr_q, addr_d, instr_q, instr_d, raddr_q, raddr_d;
    logic          fault_q, fault_d;
    logic [31:0]   mem [DEPTH];
    logic          load_ok, fetch_bad, accept, capture, hit;

    assign load_ok   = load_en && load_addr[1:0] == 2'b00 && load_addr[31:2] < 30'(DEPTH);
    assign fetch_bad = addr_q[1:0] != 2'b00 || addr_q[31:2] >= 30'(DEPTH);
    assign hit       = load_ok && load_addr[31:2] == addr_q[31:2];
    assign accept    = fetch.req_valid && fetch.req_ready;
    assign capture   = state == WAIT && cnt == '0;

    assign fetch.req_ready = state == IDLE && !load_en && rst_n;
    assign fetch.rsp_valid = state == RESP;
    assign fetch.rsp_instr = instr_q;
    assign fetch.rsp_addr  = raddr_q;
    assign fetch.rsp_fault = fault_q;
    assign busy            = state != IDLE;

    // Storage is never reset so a preloaded program survives a core reset.
    always_ff @(posedge clk)
        if (load_ok) mem[load_addr[AW+1:2]] <= load_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            raddr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            raddr_q <= raddr_d;
            fault_q <= fault_d;
        end

    // A preload landing on the captured word in the capture cycle wins (write-first).
    always_comb begin
        state_d = accept ? WAIT : capture ? RESP : (state == RESP && fetch.rsp_ready) ? IDLE : state;
        cnt_d   = accept ? CW'(LATENCY - 1) : (state == WAIT && cnt != '0) ? cnt - CW'(1) : cnt;
        addr_d  = accept ? fetch.req_addr : addr_q;
        instr_d = !capture ? instr_q : fetch_bad ? NOP : hit ? load_data : mem[addr_q[AW+1:2]];
        raddr_d = capture ? addr_q : raddr_q;
        fault_d = capture ? fetch_bad : fault_q;
    end
endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: scoreboard bench; expected responses come from a word-array memory model.
module tb_imem_fetch_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        busy;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    logic        prev_valid = 1'b0;
    logic [31:0] ref_mem [DEPTH];
    exp_t        q[$];

    imem_fetch_responder_if f();

    imem_fetch_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .fetch(f.slave),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit ok_addr(logic [31:0] a);
        return a[1:0] == 2'b00 && a[31:2] < DEPTH;
    endfunction

    always @(posedge clk) begin
        #1;
        f.rsp_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(1)) : 1'b0;
    end

    // Monitor: every valid cycle must match the head of the queue; pop on handshake.
    always @(negedge clk) begin
        if (f.rsp_valid) begin
            if (q.size() == 0) chk("stale_rsp", {31'b0, f.rsp_valid}, 32'd0);
            else begin
                if (!prev_valid) chk("latency", cyc, q[0].cyc);
                chk("rsp_instr", f.rsp_instr, q[0].instr);
                chk("rsp_addr", f.rsp_addr, q[0].addr);
                chk("rsp_fault", {31'b0, f.rsp_fault}, {31'b0, q[0].fault});
                chk("busy_resp", {31'b0, busy}, 32'd1);
                if (f.rsp_ready) void'(q.pop_front());
            end
        end
        prev_valid = f.rsp_valid;
    end

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        if (ok_addr(a)) ref_mem[int'(a[31:2])] = d;
    endtask

    // mode 0: no loads, 1: random loads in wait slots, 2: load (la, ld) in the capture slot
    task automatic fetch(input logic [31:0] a, input int mode, input logic [31:0] la, input logic [31:0] ld);
        int   n = 0;
        exp_t e;
        logic [31:0] r;
        @(negedge clk);
        f.req_valid = 1'b1;
        f.req_addr = a;
        while (!f.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("req_timeout", {31'b0, f.req_ready}, 32'd1);
            f.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        e.cyc = cyc + LATENCY;
        f.req_addr = $urandom;
        for (int s = 0; s < LATENCY; s++) begin
            chk("busy_wait", {31'b0, busy}, 32'd1);
            chk("ready_wait", {31'b0, f.req_ready}, 32'd0);
            load_en = 1'b0;
            if (mode == 1 && $urandom_range(2) == 0) begin
                r = $urandom_range(1) ? {a[31:2], 2'b00} : {22'b0, 8'($urandom), 2'b00};
                if ($urandom_range(9) == 0) r[0] = 1'b1;
                do_load(r, $urandom);
            end else if (mode == 2 && s == LATENCY - 1) do_load(la, ld);
            if (s == LATENCY - 1) begin
                e.addr = a;
                e.fault = !ok_addr(a);
                e.instr = e.fault ? NOP : ref_mem[int'(a[31:2])];
                q.push_back(e);
            end
            @(negedge clk);
        end
        load_en = 1'b0;
        f.req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        int          n;
        f.req_valid = 1'b0;
        f.req_addr = '0;
        f.rsp_ready = 1'b1;
        #1;
        chk("rst_valid", {31'b0, f.rsp_valid}, 32'd0);
        chk("rst_instr", f.rsp_instr, 32'd0);
        chk("rst_addr", f.rsp_addr, 32'd0);
        chk("rst_fault", {31'b0, f.rsp_fault}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, f.req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            do_load(32'(i * 4), i == 0 ? 32'h00500093 : i == 1 ? 32'h00A00113 :
                    i == 2 ? 32'h002081B3 : i == 3 ? 32'h00000063 : $urandom);
            @(negedge clk);
        end
        load_en = 1'b0;
        fetch(32'h0, 0, 0, 0);
        fetch(32'h4, 0, 0, 0);
        fetch(32'h8, 0, 0, 0);
        fetch(32'h6, 0, 0, 0);
        fetch(32'h400, 0, 0, 0);
        fetch(32'hFFFF_FFFC, 0, 0, 0);
        // Backpressure with a preload of the same word while the response is held.
        @(negedge clk);
        rdy_mode = 2;
        fetch(32'hC, 0, 0, 0);
        do_load(32'hC, 32'hDEADBEEF);
        @(negedge clk);
        load_en = 1'b0;
        repeat (4) @(negedge clk);
        rdy_mode = 0;
        fetch(32'hC, 0, 0, 0);
        fetch(32'h10, 2, 32'h10, 32'h12345678);
        // A preload in IDLE blocks acceptance.
        repeat (2) @(negedge clk);
        do_load(32'h20, 32'hCAFEF00D);
        f.req_valid = 1'b1;
        f.req_addr = 32'h20;
        #1 chk("ready_load", {31'b0, f.req_ready}, 32'd0);
        @(negedge clk);
        load_en = 1'b0;
        f.req_valid = 1'b0;
        chk("busy_load", {31'b0, busy}, 32'd0);
        fetch(32'h20, 0, 0, 0);
        // Async reset in the middle of WAIT drops the request.
        repeat (2) @(negedge clk);
        f.req_valid = 1'b1;
        f.req_addr = 32'h8;
        chk("ready_pre_rst", {31'b0, f.req_ready}, 32'd1);
        @(negedge clk);
        f.req_valid = 1'b0;
        chk("busy_pre_rst", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, f.rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, f.req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        fetch(32'h0, 0, 0, 0);
        // Randomized traffic with random backpressure and preload collisions.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(9);
            a = r < 7 ? {22'b0, 8'($urandom), 2'b00} :
                r == 7 ? $urandom :
                r == 8 ? {22'b0, 8'($urandom), 2'($urandom_range(1, 3))} : 32'hFFFF_FFFC;
            if ($urandom_range(3) == 0) begin
                n = 0;
                @(negedge clk);
                while (busy && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                do_load({22'b0, 8'($urandom), 2'b00}, $urandom);
                @(negedge clk);
                load_en = 1'b0;
            end
            fetch(a, 1, 0, 0);
        end
        rdy_mode = 0;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
